// File: rtl/heartbeat_monitor.sv
// Beat-period monitor: synchronizes an asynchronous beat, measures rising-edge spacing in cycles
// and flags lock, loss-of-beat and too-fast edges. Optional filter: HEARTBEAT_MONITOR_DEBOUNCE_EN.
module heartbeat_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_PERIOD = 100,
  parameter int unsigned MAX_PERIOD = 50000,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             lock,
  output logic             lost,
  output logic             too_fast,
  output logic [7:0]       beat_cnt
);

  if (MIN_PERIOD < 2 || MIN_PERIOD >= MAX_PERIOD || MAX_PERIOD >= (64'd1 << CNT_W)
      || DEB_CYCLES < 1) begin : gen_param_check
    $error("heartbeat_monitor: invalid parameter combination");
  end

  localparam logic [CNT_W-1:0] MinP = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MaxP = CNT_W'(MAX_PERIOD);

  typedef enum logic [1:0] {StIdle, StTrack, StLost} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             s1, s2, s3;
  logic             lvl;
  logic             rise;

`ifdef HEARTBEAT_MONITOR_DEBOUNCE_EN
  localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

  logic            filt;
  logic [DebW-1:0] deb_cnt;

  // filt follows s2 only after s2 has disagreed with it for DEB_CYCLES samples in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      filt    <= 1'b0;
      deb_cnt <= '0;
    end else if (s2 == filt) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DebLast) begin
      filt    <= s2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DebW'(1);
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  assign rise = lvl & ~s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      state        <= StIdle;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      lock         <= 1'b0;
      lost         <= 1'b0;
      too_fast     <= 1'b0;
      beat_cnt     <= '0;
    end else begin
      s1           <= beat_in;
      s2           <= s1;
      s3           <= lvl;
      period_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (rise) begin
            state <= StTrack;
            cnt   <= CNT_W'(1);
          end
        end
        StTrack: begin
          if (rise) begin
            if (cnt >= MinP) begin
              period       <= cnt;
              period_valid <= 1'b1;
              beat_cnt     <= beat_cnt + 8'd1;
              lock         <= 1'b1;
              cnt          <= CNT_W'(1);
            end else begin
              // rejected edge: counting continues from the last accepted rise
              too_fast <= 1'b1;
              cnt      <= cnt + CNT_W'(1);
            end
          end else if (cnt == MaxP) begin
            state <= StLost;
            lost  <= 1'b1;
            lock  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StLost: begin
          if (rise) begin
            state <= StTrack;
            cnt   <= CNT_W'(1);
            lost  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor with MIN_PERIOD=10, MAX_PERIOD=100.
module tb_heartbeat_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        beat_in = 1'b0;
  logic [15:0] period;
  logic        period_valid, lock, lost, too_fast;
  logic [7:0]  beat_cnt;

  int checks = 0;
  int errors = 0;
  int lost_cycles = 0;

  heartbeat_monitor #(
    .CNT_W     (16),
    .MIN_PERIOD(10),
    .MAX_PERIOD(100),
    .DEB_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .beat_in     (beat_in),
    .period      (period),
    .period_valid(period_valid),
    .lock        (lock),
    .lost        (lost),
    .too_fast    (too_fast),
    .beat_cnt    (beat_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (lost === 1'b1) lost_cycles++;

  typedef struct {
    bit rst_b;
    int gap;
    bit pv;
    int per;
    int bc;
    bit lk;
    bit tf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    beat_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // 2-cycle pulse starting at the current negedge; returns 3 cycles after the rising edge
  task automatic drive_pulse();
    beat_in = 1'b1;
    repeat (2) @(negedge clk);
    beat_in = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] outs_or();
    return {8'd0, period, period_valid, lock, lost, too_fast, beat_cnt} == '0 ? 32'd0 : 32'd1;
  endfunction

  initial begin
    vecs[0] = '{1, 40, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 40, 1, 40, 1, 1, 0};
    vecs[2] = '{0, 40, 1, 40, 2, 1, 0};
    vecs[3] = '{0, 40, 1, 40, 3, 1, 0};
    vecs[4] = '{0, 40, 1, 40, 4, 1, 0};
    vecs[5] = '{1, 40, 0, 0, 0, 0, 0};
    vecs[6] = '{0, 5, 1, 40, 1, 1, 0};
    vecs[7] = '{0, 35, 0, 40, 1, 1, 1};
    vecs[8] = '{0, 40, 1, 40, 2, 1, 1};

    // reset held with a toggling beat
    @(negedge clk);
    rst     = 1'b1;
    beat_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold_outs", outs_or(), 0);
      beat_in = ~beat_in;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release_outs", outs_or(), 0);
    beat_in = 1'b0;

`ifdef HEARTBEAT_MONITOR_DEBOUNCE_EN
    do_reset();
    beat_in = 1'b1;
    repeat (8) @(negedge clk);
    beat_in = 1'b0;
    repeat (32) @(negedge clk);
    beat_in = 1'b1;
    repeat (3) @(negedge clk);
    beat_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("deb_short_pv", period_valid, 0);
    chk("deb_short_tf", too_fast, 0);
    repeat (12) @(negedge clk);
    chk("deb_short_bc", beat_cnt, 0);
    @(negedge clk);
    beat_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("deb_lat_early_pv", period_valid, 0);
    @(negedge clk);
    chk("deb_lat_pv", period_valid, 1);
    chk("deb_period", period, 60);
    chk("deb_bc", beat_cnt, 1);
    chk("deb_lock", lock, 1);
    @(negedge clk);
    beat_in = 1'b0;
    chk("deb_pv_one_cycle", period_valid, 0);
`else
    // table: steady beat, then glitch scenario
    foreach (vecs[i]) begin
      if (vecs[i].rst_b) do_reset();
      drive_pulse();
      chk($sformatf("v%0d_pv", i), period_valid, vecs[i].pv);
      chk($sformatf("v%0d_period", i), period, vecs[i].per);
      chk($sformatf("v%0d_beat_cnt", i), beat_cnt, vecs[i].bc);
      chk($sformatf("v%0d_lock", i), lock, vecs[i].lk);
      chk($sformatf("v%0d_too_fast", i), too_fast, vecs[i].tf);
      chk($sformatf("v%0d_lost", i), lost, 0);
      @(negedge clk);
      if (vecs[i].pv) chk($sformatf("v%0d_pv_one_cycle", i), period_valid, 0);
      repeat (vecs[i].gap - 4) @(negedge clk);
    end
    chk("glitch_tf_sticky", too_fast, 1);

    // timeout and recovery
    do_reset();
    drive_pulse();
    repeat (99) @(negedge clk);
    chk("timeout_lost_early", lost, 0);
    @(negedge clk);
    chk("timeout_lost", lost, 1);
    chk("timeout_lock", lock, 0);
    repeat (7) @(negedge clk);
    drive_pulse();
    chk("recover_lost_clear", lost, 0);
    chk("recover_no_pv", period_valid, 0);
    chk("recover_lock_low", lock, 0);
    repeat (17) @(negedge clk);
    drive_pulse();
    chk("recover_pv", period_valid, 1);
    chk("recover_period", period, 20);
    chk("recover_lock", lock, 1);

    // boundaries: exactly MIN and MAX spacing, then beat_cnt wrap
    do_reset();
    begin
      int lost_base;
      lost_base = lost_cycles;
      drive_pulse();
      repeat (7) @(negedge clk);
      drive_pulse();
      chk("min_pv", period_valid, 1);
      chk("min_period", period, 10);
      repeat (97) @(negedge clk);
      drive_pulse();
      chk("max_pv", period_valid, 1);
      chk("max_period", period, 100);
      chk("max_lost", lost, 0);
      for (int i = 0; i < 297; i++) begin
        repeat (7) @(negedge clk);
        drive_pulse();
      end
      chk("wrap_beat_cnt", beat_cnt, 43);
      chk("wrap_period", period, 10);
      chk("boundary_never_lost", lost_cycles - lost_base, 0);
    end

    // mid-operation reset with an edge in flight
    rst     = 1'b1;
    beat_in = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    beat_in = 1'b0;
    chk("midrst_outs", outs_or(), 0);
    repeat (10) @(negedge clk);
    chk("midrst_settled_outs", outs_or(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
